// File: rtl/matrix_streamer.sv
// matrix_streamer: snapshots a ROWSxCOLS cell bus on load and streams the cells
// one per valid/ready transfer with row/col/last tags and a frame checksum.
module matrix_streamer #(
  parameter int ROWS = 2,
  parameter int COLS = 3,
  parameter int W    = 8,
  parameter int SUMW = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ROWS*COLS*W-1:0] flat,
  input  logic                   load,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [W-1:0]           out_data,
  output logic [7:0]             out_row,
  output logic [7:0]             out_col,
  output logic                   out_last,
  output logic                   busy,
  output logic [SUMW-1:0]        sum,
  output logic                   sum_valid
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t                 state_q, state_d;
  logic [ROWS*COLS*W-1:0] shadow_q, shadow_d;
  logic [SUMW-1:0]        acc_q, acc_d, sum_q, sum_d, acc_next;
  logic                   out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic                   sum_valid_q, sum_valid_d;
  logic [W-1:0]           out_data_q, out_data_d;
  logic [7:0]             out_row_q, out_row_d, out_col_q, out_col_d, nrow, ncol;
  logic [15:0]            nidx;
  logic                   xfer, wrap, done, capture;
  always_comb begin
    xfer        = out_valid_q && out_ready;
    done        = xfer && out_last_q;
    capture     = (state_q == IDLE) ? load : (done && load);
    wrap        = out_col_q == 8'(COLS - 1);
    ncol        = wrap ? 8'd0 : out_col_q + 8'd1;
    nrow        = wrap ? out_row_q + 8'd1 : out_row_q;
    nidx        = 16'(nrow) * 16'(COLS) + 16'(ncol);
    acc_next    = acc_q + SUMW'(out_data_q);
    state_d     = state_q;
    shadow_d    = shadow_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    sum_d       = done ? acc_next : sum_q;
    sum_valid_d = done;
    if (capture) begin
      state_d     = SEND;
      shadow_d    = flat;
      acc_d       = '0;
      out_valid_d = 1'b1;
      out_last_d  = (ROWS * COLS == 1);
      out_data_d  = flat[W-1:0];
      out_row_d   = '0;
      out_col_d   = '0;
    end else if (done) begin
      state_d     = IDLE;
      acc_d       = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_data_d  = '0;
      out_row_d   = '0;
      out_col_d   = '0;
    end else if (xfer) begin
      acc_d       = acc_next;
      out_row_d   = nrow;
      out_col_d   = ncol;
      out_data_d  = shadow_q[nidx*W +: W];
      out_last_d  = nrow == 8'(ROWS - 1) && ncol == 8'(COLS - 1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;
  assign busy      = state_q == SEND;
  assign sum       = sum_q;
  assign sum_valid = sum_valid_q;
endmodule

// File: tb/tb_matrix_streamer.sv
// tb_matrix_streamer: directed scoreboard bench for matrix_streamer.
module tb_matrix_streamer;
  logic        clk = 1'b0, rst = 1'b1, load = 1'b0, out_ready = 1'b0;
  logic [47:0] flat = '0;
  logic        out_valid, out_last, busy, sum_valid;
  logic [7:0]  out_data, out_row, out_col;
  logic [10:0] sum;
  logic [24:0] exp_q[$];
  logic [10:0] sum_exp_q[$];
  logic [10:0] last_sum = '0, pend_sum = '0;
  logic        pend = 1'b0;
  int          checks = 0, failures = 0;

  matrix_streamer dut (
    .clk(clk), .rst(rst), .flat(flat), .load(load), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .busy(busy), .sum(sum), .sum_valid(sum_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [47:0] f);
    logic [10:0] s = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++) begin
        exp_q.push_back({f[(r*3+c)*8 +: 8], 8'(r), 8'(c), (r == 1 && c == 2)});
        s += 11'(f[(r*3+c)*8 +: 8]);
      end
    sum_exp_q.push_back(s);
  endtask

  // One clock: drive at negedge, check the transfer about to happen, then check sum after the edge.
  task automatic tick(input logic r, input logic l);
    logic [24:0] e;
    @(negedge clk);
    out_ready = r;
    load = l;
    #1;
    pend = 1'b0;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("extra_out", {63'd0, out_valid}, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("cell", {39'd0, out_data, out_row, out_col, out_last}, {39'd0, e});
        if (e[0]) begin
          pend = 1'b1;
          pend_sum = sum_exp_q.pop_front();
        end
      end
    end
    @(posedge clk);
    #1;
    load = 1'b0;
    chk("sum_valid", {63'd0, sum_valid}, {63'd0, pend});
    if (pend) last_sum = pend_sum;
    chk("sum", {53'd0, sum}, {53'd0, last_sum});
  endtask

  task automatic drain(input int mode);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      tick(mode == 0 ? 1'b1 : (n % 3 == 0), 1'b0);
      n++;
    end
    chk("drained_busy", {63'd0, busy}, 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #12;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_sum", {53'd0, sum}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    // test 1: back-to-back streaming, latency 1
    flat = 48'h060504030201;
    push_frame(flat);
    tick(1'b1, 1'b1);
    chk("lat_valid", {63'd0, out_valid}, 64'd1);
    chk("lat_busy", {63'd0, busy}, 64'd1);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
    chk("t1_idle", {63'd0, busy}, 64'd0);
    chk("t1_empty", 64'(exp_q.size()), 64'd0);
    chk("t1_sum", {53'd0, sum}, 64'd21);
    tick(1'b1, 1'b0);
    // test 2: stalled stream
    push_frame(flat);
    tick(1'b0, 1'b1);
    drain(1);
    chk("t2_sum", {53'd0, sum}, 64'd21);
    // test 3: all-ones frame
    flat = {48{1'b1}};
    push_frame(flat);
    tick(1'b0, 1'b1);
    drain(0);
    chk("t3_sum", {53'd0, sum}, 64'd1530);
    // test 4: ignored mid-frame load, then reload on the last transfer
    flat = 48'h0A0908070605;
    push_frame(flat);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    flat = 48'hF0E0D0C0B0A0;
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    flat = 48'h1122334455AA;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    chk("t4_last_flag", {63'd0, out_last}, 64'd1);
    push_frame(flat);
    tick(1'b1, 1'b1);
    chk("t4_busy_kept", {63'd0, busy}, 64'd1);
    chk("t4_valid_kept", {63'd0, out_valid}, 64'd1);
    chk("t4_sum_first", {53'd0, sum}, 64'd45);
    drain(0);
    // test 5: asynchronous reset mid-frame
    flat = 48'h605040302010;
    push_frame(flat);
    tick(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", {63'd0, out_valid}, 64'd0);
    chk("ar_busy", {63'd0, busy}, 64'd0);
    chk("ar_data", {56'd0, out_data}, 64'd0);
    chk("ar_rowcol", {48'd0, out_row, out_col}, 64'd0);
    chk("ar_sum", {53'd0, sum}, 64'd0);
    chk("ar_sum_valid", {63'd0, sum_valid}, 64'd0);
    exp_q.delete();
    sum_exp_q.delete();
    last_sum = '0;
    tick(1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    flat = 48'h0C0B0A090807;
    push_frame(flat);
    tick(1'b1, 1'b1);
    drain(0);
    chk("t5_sum", {53'd0, sum}, 64'd57);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
